// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single main-memory port shared by the cache controller (req0)
// and the I/O/DMA engine (req1). One access in flight, fixed MEM_LAT memory latency.
module mem_port_arbiter #(
   parameter int AW      = 16,
   parameter int DW      = 32,
   parameter int MEM_LAT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          Strobe0,
   input  logic          RW0,
   input  logic [AW-1:0] Addr0,
   input  logic [DW-1:0] WData0,
   output logic          Rdy0,
   output logic [DW-1:0] RData0,
   input  logic          Strobe1,
   input  logic          RW1,
   input  logic [AW-1:0] Addr1,
   input  logic [DW-1:0] WData1,
   output logic          Rdy1,
   output logic [DW-1:0] RData1,
   output logic [1:0]    Gnt,
   output logic          Busy,
   output logic          MStrobe,
   output logic          MRW,
   output logic [AW-1:0] MAddr,
   output logic [DW-1:0] MWData,
   input  logic [DW-1:0] MRData
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t        r_state;
   logic [3:0]    r_ctr;
   logic          r_last_gnt;
   logic [1:0]    r_gnt;
   logic          r_busy;
   logic          r_mstrobe;
   logic          r_mrw;
   logic [AW-1:0] r_maddr;
   logic [DW-1:0] r_mwdata;
   logic          r_rdy0;
   logic          r_rdy1;
   logic [DW-1:0] r_rdata0;
   logic [DW-1:0] r_rdata1;

   logic w_req0;
   logic w_req1;
   logic w_pick1;

   // A requester still showing its Rdy pulse is finishing its handshake, not asking again.
   assign w_req0  = Strobe0 & ~r_rdy0;
   assign w_req1  = Strobe1 & ~r_rdy1;
   // On a tie the requester that was not served last wins.
   assign w_pick1 = w_req1 & (~w_req0 | ~r_last_gnt);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_ctr      <= '0;
         r_last_gnt <= 1'b1;
         r_gnt      <= 2'b00;
         r_busy     <= 1'b0;
         r_mstrobe  <= 1'b0;
         r_mrw      <= 1'b0;
         r_maddr    <= '0;
         r_mwdata   <= '0;
         r_rdy0     <= 1'b0;
         r_rdy1     <= 1'b0;
         r_rdata0   <= '0;
         r_rdata1   <= '0;
      end else begin
         r_mstrobe <= 1'b0;
         r_rdy0    <= 1'b0;
         r_rdy1    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_req0 | w_req1) begin
                  r_gnt    <= w_pick1 ? 2'b10 : 2'b01;
                  r_busy   <= 1'b1;
                  r_mrw    <= w_pick1 ? RW1 : RW0;
                  r_maddr  <= w_pick1 ? Addr1 : Addr0;
                  r_mwdata <= w_pick1 ? WData1 : WData0;
                  r_state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_mstrobe <= 1'b1;
               r_ctr     <= LAT_M1;
               r_state   <= S_WAIT;
            end
            S_WAIT: begin
               if (r_ctr != 4'd0) begin
                  r_ctr <= r_ctr - 4'd1;
               end else begin
                  if (!r_mrw) begin
                     if (r_gnt[0]) r_rdata0 <= MRData;
                     else          r_rdata1 <= MRData;
                  end
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_rdy0     <= r_gnt[0];
               r_rdy1     <= r_gnt[1];
               r_last_gnt <= r_gnt[1];
               r_gnt      <= 2'b00;
               r_busy     <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign Gnt     = r_gnt;
   assign Busy    = r_busy;
   assign MStrobe = r_mstrobe;
   assign MRW     = r_mrw;
   assign MAddr   = r_maddr;
   assign MWData  = r_mwdata;
   assign Rdy0    = r_rdy0;
   assign Rdy1    = r_rdy1;
   assign RData0  = r_rdata0;
   assign RData1  = r_rdata1;

endmodule
